// File: rtl/transport_pkg.sv
// Shared definitions for the transport link: FSM states, header layout, cmd codes
// and the running checksum step used by both the transmit and receive ends.
package transport_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CSUM    = 3'd4
  } tx_state_t;

  localparam int CMD_MSB = 7;
  localparam int CMD_LSB = 6;
  localparam int LEN_MSB = 5;
  localparam int LEN_LSB = 0;

  localparam logic [1:0] CMD_0 = 2'b00;
  localparam logic [1:0] CMD_1 = 2'b01;
  localparam logic [1:0] CMD_2 = 2'b10;
  localparam logic [1:0] CMD_3 = 2'b11;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic [7:0] make_header(input logic [1:0] c, input logic [5:0] len);
    logic [7:0] h;
    h = '0;
    h[CMD_MSB:CMD_LSB] = c;
    h[LEN_MSB:LEN_LSB] = len;
    return h;
  endfunction

endpackage

// File: rtl/transport_word_fifo.sv
// Show-ahead 16-bit word FIFO with occupancy count. Also exposes the high byte of
// the word behind the head so the framer can register it without a bubble.
module transport_word_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [15:0]           push_data,
  input  logic                  pop,
  output logic [15:0]           head,
  output logic [7:0]            next_head_hi,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_next;
  logic                  do_push;
  logic                  do_pop;
  logic [15:0]           next_word;

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign do_push      = push && !full;
  assign do_pop       = pop && !empty;
  assign rd_next      = rd_ptr + PTR_ONE;
  assign head         = mem[rd_ptr];
  assign next_word    = mem[rd_next];
  assign next_head_hi = next_word[15:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/transport_frame_tx.sv
// Transmit end of the transport link: buffers session words and emits frames of
// {cmd,len} header, MSB-first data bytes and an XOR checksum on an 8-bit link.
module transport_frame_tx
  import transport_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int MAX_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            cmd,
  input  logic [15:0]           data,
  input  logic                  wrEn,
  input  logic                  sendData,
  input  logic                  linkReady,
  output logic                  sending,
  output logic [7:0]            packetOut,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   ready_data_count,
  output logic                  overrun,
  output tx_state_t             fsm_state
);

  localparam logic [DEPTH_LOG2:0] MAX_CNT = (DEPTH_LOG2+1)'(MAX_WORDS);

  // Link handshake: a byte transfers on every rising edge where sending=1 and
  // linkReady=1; while linkReady=0 packetOut and sending hold their values.
  logic        accept;
  logic        start;
  logic [1:0]  cur_cmd;
  logic        pend_valid;
  logic [1:0]  pend_cmd;
  logic [15:0] pend_word;
  logic        flush_req;
  logic        push_wr;
  logic        to_pend;
  logic        push_pend;
  logic        fifo_push;
  logic [15:0] fifo_data;
  logic        fifo_pop;
  logic [15:0] head;
  logic [7:0]  next_head_hi;
  logic        fifo_full;
  logic        fifo_empty;
  logic [5:0]  len_now;
  logic [5:0]  words_left;
  logic [7:0]  csum;

  assign busy      = fifo_full | pend_valid;
  assign push_wr   = wrEn && !busy && (fifo_empty || (cmd == cur_cmd));
  assign to_pend   = wrEn && !busy && !fifo_empty && (cmd != cur_cmd);
  assign push_pend = pend_valid && fifo_empty;
  assign fifo_push = push_wr || push_pend;
  assign fifo_data = push_pend ? pend_word : data;
  assign accept    = sending && linkReady;
  assign fifo_pop  = (fsm_state == ST_DATA_LO) && accept;
  assign start     = (fsm_state == ST_IDLE) && !fifo_empty &&
                     (flush_req || pend_valid || (ready_data_count >= MAX_CNT));
  assign len_now   = (ready_data_count >= MAX_CNT) ? 6'(MAX_WORDS) : 6'(ready_data_count);

  transport_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .push_data    (fifo_data),
    .pop          (fifo_pop),
    .head         (head),
    .next_head_hi (next_head_hi),
    .count        (ready_data_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // A word with a new cmd waits in the pending slot until the current run drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_cmd    <= '0;
      pend_valid <= 1'b0;
      pend_cmd   <= '0;
      pend_word  <= '0;
      flush_req  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (to_pend) begin
        pend_valid <= 1'b1;
        pend_cmd   <= cmd;
        pend_word  <= data;
      end else if (push_pend) begin
        pend_valid <= 1'b0;
      end
      if (push_wr)        cur_cmd <= cmd;
      else if (push_pend) cur_cmd <= pend_cmd;
      if (start)          flush_req <= 1'b0;
      else if (sendData)  flush_req <= 1'b1;
      if (wrEn && busy)   overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_state  <= ST_IDLE;
      sending    <= 1'b0;
      packetOut  <= '0;
      words_left <= '0;
      csum       <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (start) begin
            fsm_state  <= ST_HDR;
            sending    <= 1'b1;
            packetOut  <= make_header(cur_cmd, len_now);
            csum       <= make_header(cur_cmd, len_now);
            words_left <= len_now;
          end
        end
        ST_HDR: begin
          if (accept) begin
            fsm_state <= ST_DATA_HI;
            packetOut <= head[15:8];
            csum      <= csum_step(csum, head[15:8]);
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            fsm_state <= ST_DATA_LO;
            packetOut <= head[7:0];
            csum      <= csum_step(csum, head[7:0]);
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            words_left <= words_left - 6'd1;
            if (words_left == 6'd1) begin
              fsm_state <= ST_CSUM;
              packetOut <= csum;
            end else begin
              // Head is popped this edge, so the next word's high byte comes from behind it.
              fsm_state <= ST_DATA_HI;
              packetOut <= next_head_hi;
              csum      <= csum_step(csum, next_head_hi);
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            fsm_state <= ST_IDLE;
            sending   <= 1'b0;
            packetOut <= '0;
          end
        end
        default: begin
          fsm_state <= ST_IDLE;
          sending   <= 1'b0;
          packetOut <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transport_frame_tx.sv
// Directed bench for transport_frame_tx: link bytes are checked against an expected
// byte queue built from the words written, plus point checks on status outputs.
module tb_transport_frame_tx;
  import transport_pkg::*;

  localparam int DL = 4;
  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [15:0] data;
  logic        wrEn;
  logic        sendData;
  logic        linkReady;
  logic        sending;
  logic [7:0]  packetOut;
  logic        busy;
  logic [DL:0] ready_data_count;
  logic        overrun;
  tx_state_t   fsm_state;

  logic [7:0]  exp_q[$];
  logic [15:0] model_q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  transport_frame_tx #(.DEPTH_LOG2(DL), .MAX_WORDS(MW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd              (cmd),
    .data             (data),
    .wrEn             (wrEn),
    .sendData         (sendData),
    .linkReady        (linkReady),
    .sending          (sending),
    .packetOut        (packetOut),
    .busy             (busy),
    .ready_data_count (ready_data_count),
    .overrun          (overrun),
    .fsm_state        (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte transferred on the link must match the queue head.
  always @(negedge clk) begin
    if (reset && sending && linkReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL stray_byte: observed=%0h expected=none", packetOut);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("link_byte", 32'(packetOut), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [1:0] c, input logic [15:0] d);
    cmd  = c;
    data = d;
    wrEn = 1'b1;
    step();
    wrEn = 1'b0;
    model_q.push_back(d);
  endtask

  task automatic write_rand(input logic [1:0] c);
    logic [15:0] w;
    w = 16'($urandom_range(0, 65535));
    write_word(c, w);
  endtask

  task automatic pulse_send();
    sendData = 1'b1;
    step();
    sendData = 1'b0;
  endtask

  // Expected frame built from the oldest n modelled words.
  task automatic queue_frame(input logic [1:0] c, input int n);
    logic [7:0] x;
    x = {c, 6'(n)};
    exp_q.push_back(x);
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      w = model_q.pop_front();
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_sending();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sending) seen = 1'b1;
    end
    check("wait_sending", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!sending && exp_q.size() == 0) done = 1'b1;
    end
    check("wait_idle", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    reset = 1'b0; cmd = '0; data = '0; wrEn = 1'b0; sendData = 1'b0; linkReady = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sending", 32'(sending), 32'd0);
    check("rst_packet", 32'(packetOut), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(ready_data_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Basic two-word frame with literal expected bytes.
    write_word(CMD_1, 16'hA1B2);
    write_word(CMD_1, 16'hC3D4);
    model_q.delete();
    exp_q.push_back(8'h42); exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4); exp_q.push_back(8'h46);
    pulse_send();
    wait_sending();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("basic_consecutive", 32'(sending), 32'd1);
    end
    @(negedge clk);
    check("basic_end", 32'(sending), 32'd0);
    check("basic_count", 32'(ready_data_count), 32'd0);
    check("basic_drained", 32'(exp_q.size()), 32'd0);

    // Auto-flush at MAX_WORDS without sendData.
    step();
    for (int i = 0; i < MW; i++) write_rand(CMD_2);
    queue_frame(CMD_2, MW);
    wait_idle();
    check("auto_count", 32'(ready_data_count), 32'd0);

    // Stall in DATA_HI for three cycles.
    linkReady = 1'b0;
    write_word(CMD_1, 16'h5A3C);
    write_word(CMD_1, 16'h9F01);
    queue_frame(CMD_1, 2);
    pulse_send();
    wait_sending();
    step();
    linkReady = 1'b1;
    step();
    linkReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sending", 32'(sending), 32'd1);
      check("stall_byte", 32'(packetOut), 32'h5A);
    end
    step();
    linkReady = 1'b1;
    wait_idle();

    // Fill to depth with the link stalled, then overrun.
    step();
    linkReady = 1'b0;
    for (int i = 0; i < (1 << DL); i++) write_rand(CMD_0);
    @(negedge clk);
    check("full_busy", 32'(busy), 32'd1);
    check("full_count", 32'(ready_data_count), 32'd16);
    check("full_no_overrun", 32'(overrun), 32'd0);
    step();
    cmd = CMD_0; data = 16'hDEAD; wrEn = 1'b1;
    step();
    wrEn = 1'b0;
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_count", 32'(ready_data_count), 32'd16);
    queue_frame(CMD_0, MW);
    queue_frame(CMD_0, MW);
    step();
    linkReady = 1'b1;
    wait_idle();
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("drain_count", 32'(ready_data_count), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    // Cmd change forces a flush and parks the new word.
    step();
    write_rand(CMD_1);
    write_rand(CMD_1);
    write_word(CMD_3, 16'h1234);
    queue_frame(CMD_1, 2);
    @(negedge clk);
    check("cmdchg_busy", 32'(busy), 32'd1);
    wait_idle();
    check("cmdchg_count", 32'(ready_data_count), 32'd1);
    check("cmdchg_busy_clear", 32'(busy), 32'd0);
    step();
    queue_frame(CMD_3, 1);
    pulse_send();
    wait_sending();
    check("cmdchg_hdr", 32'(packetOut), 32'hC1);
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    step();
    write_rand(CMD_2);
    write_rand(CMD_2);
    write_rand(CMD_2);
    queue_frame(CMD_2, 3);
    pulse_send();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (fsm_state == ST_DATA_LO) found = 1'b1;
    end
    check("reach_data_lo", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_sending", 32'(sending), 32'd0);
    check("midrst_count", 32'(ready_data_count), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_packet", 32'(packetOut), 32'd0);
    exp_q.delete();
    model_q.delete();
    step();
    reset = 1'b1;
    step();
    write_word(CMD_1, 16'h0F0F);
    write_word(CMD_1, 16'hF00F);
    queue_frame(CMD_1, 2);
    pulse_send();
    wait_idle();
    check("post_rst_count", 32'(ready_data_count), 32'd0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
